// File: rtl/shift_fifo.sv
// shift_fifo: first-word-fall-through elastic FIFO on a shift-register array read at the fill level
module shift_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AFULL_LEVEL = 12,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CW-1:0] count,
  output logic almost_full,
  output logic overflow
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] head_idx;
  logic push, pop;
  assign in_ready = count != CW'(DEPTH);
  assign out_valid = count != '0;
  assign almost_full = count >= CW'(AFULL_LEVEL);
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign head_idx = AW'(count - CW'(1));
  assign out_data = out_valid ? mem[head_idx] : '0;
  // every accepted write shifts the whole array; the oldest word sits at count-1
  always_ff @(posedge clk)
    if (push) begin
      mem[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  // fill level and sticky overflow; flush wins over push and pop
  always_ff @(posedge clk)
    if (rst) begin
      count <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= (push & !pop) ? count + CW'(1) : (pop & !push) ? count - CW'(1) : count;
      if (in_valid & !in_ready) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_shift_fifo.sv
// tb_shift_fifo: directed-vector check of shift_fifo handshakes, ordering, flush and reset
module tb_shift_fifo;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic in_ready, out_valid, almost_full, overflow;
  logic [7:0] out_data;
  logic [4:0] count;
  int n_chk = 0, n_pass = 0;

  shift_fifo dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .almost_full(almost_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    in_valid = 1;
    in_data = d;
    step();
    in_valid = 0;
  endtask

  initial begin
    step();
    step();
    rst = 0;
    step();
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_afull", almost_full, 0);

    push_word(8'h11);
    chk("fwft_valid", out_valid, 1);
    chk("fwft_data", out_data, 8'h11);
    push_word(8'h22);
    push_word(8'h33);
    chk("three_count", count, 3);
    chk("three_head", out_data, 8'h11);
    out_ready = 1;
    chk("pop0", out_data, 8'h11);
    step();
    chk("pop1", out_data, 8'h22);
    step();
    chk("pop2", out_data, 8'h33);
    step();
    out_ready = 0;
    chk("drained_count", count, 0);
    chk("drained_valid", out_valid, 0);
    step();
    chk("idle_pop_count", count, 0);

    for (int i = 0; i < 16; i++) begin
      push_word(8'(i));
      if (i == 10) chk("afull_at11", almost_full, 0);
      if (i == 11) chk("afull_at12", almost_full, 1);
    end
    chk("full_count", count, 16);
    chk("full_in_ready", in_ready, 0);
    chk("full_afull", almost_full, 1);
    chk("full_no_ovf", overflow, 0);
    push_word(8'hAA);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);
    in_valid = 1;
    in_data = 8'hAB;
    out_ready = 1;
    step();
    in_valid = 0;
    chk("full_pushpop_refused", count, 15);
    chk("full_pushpop_head", out_data, 8'h01);
    for (int i = 1; i < 16; i++) begin
      chk("drain_data", out_data, 32'(i));
      step();
    end
    out_ready = 0;
    chk("drain_empty", count, 0);
    chk("ovf_sticky", overflow, 1);

    for (int i = 0; i < 5; i++) push_word(8'h40 + 8'(i));
    in_valid = 1;
    out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      in_data = 8'h45 + 8'(k);
      chk("steady_data", out_data, 32'h40 + 32'(k));
      step();
      chk("steady_count", count, 5);
    end
    in_valid = 0;
    for (int k = 0; k < 5; k++) begin
      chk("steady_tail", out_data, 32'h4A + 32'(k));
      step();
    end
    out_ready = 0;
    chk("steady_empty", count, 0);

    for (int i = 0; i < 7; i++) push_word(8'h60 + 8'(i));
    chk("pre_flush_count", count, 7);
    flush = 1;
    in_valid = 1;
    in_data = 8'h55;
    step();
    flush = 0;
    in_valid = 0;
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_ovf_kept", overflow, 1);
    push_word(8'h77);
    chk("post_flush_data", out_data, 8'h77);
    chk("post_flush_count", count, 1);
    out_ready = 1;
    step();
    out_ready = 0;

    for (int i = 0; i < 9; i++) push_word(8'h80 + 8'(i));
    chk("pre_rst_count", count, 9);
    chk("pre_rst_ovf", overflow, 1);
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    push_word(8'hC3);
    push_word(8'hD4);
    chk("post_rst_head", out_data, 8'hC3);
    out_ready = 1;
    step();
    chk("post_rst_next", out_data, 8'hD4);
    step();
    out_ready = 0;
    chk("post_rst_empty", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
